// File: rtl/lcd_pkg.sv
// Shared constants, state enums and command helpers for the LCD text writer.
// Macro LCD_CURSOR_EN selects the cursor/blink display-control init command.
package lcd_pkg;

   localparam logic [7:0] CMD_FUNC_SET    = 8'h38;
   localparam logic [7:0] CMD_DISP_ON     = 8'h0C;
   localparam logic [7:0] CMD_DISP_CURSOR = 8'h0F;
   localparam logic [7:0] CMD_ENTRY       = 8'h06;
   localparam logic [7:0] CMD_CLEAR       = 8'h01;
   localparam logic [7:0] CMD_SET_DDRAM   = 8'h80;

   localparam logic [6:0] ROW0_BASE = 7'h00;
   localparam logic [6:0] ROW1_BASE = 7'h40;

   localparam logic [7:0] CHAR_NL = 8'h0A;
   localparam logic [7:0] CHAR_FF = 8'h0C;

`ifdef LCD_CURSOR_EN
   localparam logic [7:0] CMD_DISP_CTRL = CMD_DISP_CURSOR;
`else
   localparam logic [7:0] CMD_DISP_CTRL = CMD_DISP_ON;
`endif

   typedef enum logic [1:0] {
      SEQ_INIT,
      SEQ_READY,
      SEQ_EXEC
   } seq_state_e;

   typedef enum logic [1:0] {
      HS_IDLE,
      HS_SEND,
      HS_RELEASE
   } hs_state_e;

   function automatic logic [7:0] ddram_cmd(input logic row);
      return CMD_SET_DDRAM | {1'b0, (row ? ROW1_BASE : ROW0_BASE)};
   endfunction

   function automatic logic [7:0] init_cmd(input logic [1:0] step);
      case (step)
         2'd0:    return CMD_FUNC_SET;
         2'd1:    return CMD_DISP_CTRL;
         2'd2:    return CMD_ENTRY;
         default: return CMD_CLEAR;
      endcase
   endfunction

endpackage

// File: rtl/lcd_req_sender.sv
// Four-phase req/ack engine: launches one byte per start, reports done once
// the controller has released ack.
module lcd_req_sender
   import lcd_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       start_i,
   input  logic [7:0] byte_i,
   input  logic       is_cmd_i,
   input  logic       ack_i,
   output logic       req_o,
   output logic [7:0] data_o,
   output logic       is_cmd_o,
   output logic       done_o,
   output logic       idle_o
);

   hs_state_e  state_q, state_d;
   logic [7:0] data_q, data_d;
   logic       cmd_q, cmd_d;

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= HS_IDLE;
         data_q  <= '0;
         cmd_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         data_q  <= data_d;
         cmd_q   <= cmd_d;
      end
   end

   always_comb begin
      state_d = state_q;
      data_d  = data_q;
      cmd_d   = cmd_q;
      done_o  = 1'b0;
      case (state_q)
         // A new transfer only starts once any stale ack has been released.
         HS_IDLE: begin
            if (start_i && !ack_i) begin
               state_d = HS_SEND;
               data_d  = byte_i;
               cmd_d   = is_cmd_i;
            end
         end
         HS_SEND: begin
            if (ack_i) state_d = HS_RELEASE;
         end
         HS_RELEASE: begin
            if (!ack_i) begin
               state_d = HS_IDLE;
               done_o  = 1'b1;
            end
         end
         default: state_d = HS_IDLE;
      endcase
   end

   assign req_o    = (state_q == HS_SEND);
   assign idle_o   = (state_q == HS_IDLE);
   assign data_o   = data_q;
   assign is_cmd_o = cmd_q;

endmodule

// File: rtl/lcd_text_writer.sv
// Text front-end for an HD44780-style controller: init sequence, cursor
// tracking, line wrap, newline/form-feed. LCD_CURSOR_EN enables cursor+blink.
module lcd_text_writer
   import lcd_pkg::*;
#(
   parameter int unsigned COLS = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] char_in,
   input  logic       char_valid,
   output logic       char_ready,
   output logic       init_done,
   output logic [7:0] lcd_data,
   output logic       lcd_is_cmd,
   output logic       lcd_req,
   input  logic       lcd_ack
);

   localparam logic [5:0] COL_LAST = 6'(COLS - 1);

   seq_state_e seq_q, seq_d;
   logic [1:0] step_q, step_d;
   logic       init_done_q, init_done_d;
   logic       row_q, row_d;
   logic [5:0] col_q, col_d;
   logic [7:0] cur_byte_q, cur_byte_d;
   logic       cur_cmd_q, cur_cmd_d;
   logic [7:0] nxt_byte_q, nxt_byte_d;
   logic       has_nxt_q, has_nxt_d;

   logic       snd_start, snd_cmd, snd_done, snd_idle;
   logic [7:0] snd_byte;

   lcd_req_sender u_sender (
      .clk      (clk),
      .rst      (rst),
      .start_i  (snd_start),
      .byte_i   (snd_byte),
      .is_cmd_i (snd_cmd),
      .ack_i    (lcd_ack),
      .req_o    (lcd_req),
      .data_o   (lcd_data),
      .is_cmd_o (lcd_is_cmd),
      .done_o   (snd_done),
      .idle_o   (snd_idle)
   );

   always_ff @(posedge clk) begin
      if (!rst) begin
         seq_q       <= SEQ_INIT;
         step_q      <= '0;
         init_done_q <= 1'b0;
         row_q       <= 1'b0;
         col_q       <= '0;
         cur_byte_q  <= '0;
         cur_cmd_q   <= 1'b0;
         nxt_byte_q  <= '0;
         has_nxt_q   <= 1'b0;
      end else begin
         seq_q       <= seq_d;
         step_q      <= step_d;
         init_done_q <= init_done_d;
         row_q       <= row_d;
         col_q       <= col_d;
         cur_byte_q  <= cur_byte_d;
         cur_cmd_q   <= cur_cmd_d;
         nxt_byte_q  <= nxt_byte_d;
         has_nxt_q   <= has_nxt_d;
      end
   end

   always_comb begin
      seq_d       = seq_q;
      step_d      = step_q;
      init_done_d = init_done_q;
      row_d       = row_q;
      col_d       = col_q;
      cur_byte_d  = cur_byte_q;
      cur_cmd_d   = cur_cmd_q;
      nxt_byte_d  = nxt_byte_q;
      has_nxt_d   = has_nxt_q;
      snd_start   = 1'b0;
      snd_byte    = cur_byte_q;
      snd_cmd     = cur_cmd_q;
      char_ready  = (seq_q == SEQ_READY) && init_done_q && snd_idle;
      case (seq_q)
         SEQ_INIT: begin
            snd_byte  = init_cmd(step_q);
            snd_cmd   = 1'b1;
            snd_start = snd_idle;
            if (snd_done) begin
               if (step_q == 2'd3) begin
                  seq_d       = SEQ_READY;
                  init_done_d = 1'b1;
                  row_d       = 1'b0;
                  col_d       = '0;
               end else begin
                  step_d = step_q + 2'd1;
               end
            end
         end
         // Cursor is advanced at acceptance; the first transfer is launched
         // straight from the decoded byte so req rises on the next cycle.
         SEQ_READY: begin
            if (char_ready && char_valid) begin
               seq_d      = SEQ_EXEC;
               snd_start  = 1'b1;
               has_nxt_d  = 1'b0;
               nxt_byte_d = ddram_cmd(!row_q);
               if (char_in == CHAR_NL) begin
                  cur_byte_d = ddram_cmd(!row_q);
                  cur_cmd_d  = 1'b1;
                  row_d      = !row_q;
                  col_d      = '0;
               end else if (char_in == CHAR_FF) begin
                  cur_byte_d = CMD_CLEAR;
                  cur_cmd_d  = 1'b1;
                  row_d      = 1'b0;
                  col_d      = '0;
               end else begin
                  cur_byte_d = char_in;
                  cur_cmd_d  = 1'b0;
                  if (col_q == COL_LAST) begin
                     has_nxt_d = 1'b1;
                     row_d     = !row_q;
                     col_d     = '0;
                  end else begin
                     col_d = col_q + 6'd1;
                  end
               end
               snd_byte = cur_byte_d;
               snd_cmd  = cur_cmd_d;
            end
         end
         SEQ_EXEC: begin
            snd_start = snd_idle;
            if (snd_done) begin
               if (has_nxt_q) begin
                  cur_byte_d = nxt_byte_q;
                  cur_cmd_d  = 1'b1;
                  has_nxt_d  = 1'b0;
               end else begin
                  seq_d = SEQ_READY;
               end
            end
         end
         default: seq_d = SEQ_INIT;
      endcase
   end

   assign init_done = init_done_q;

endmodule

// File: tb/tb_lcd_text_writer.sv
// Self-checking bench for lcd_text_writer with a 4-phase controller model.
module tb_lcd_text_writer;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic [7:0] char_in = '0;
   logic       char_valid = 1'b0;
   logic       char_ready, init_done, lcd_is_cmd, lcd_req;
   logic [7:0] lcd_data;
   logic       lcd_ack = 1'b0;

   always #5 clk = ~clk;

   lcd_text_writer #(.COLS(16)) dut (
      .clk        (clk),
      .rst        (rst),
      .char_in    (char_in),
      .char_valid (char_valid),
      .char_ready (char_ready),
      .init_done  (init_done),
      .lcd_data   (lcd_data),
      .lcd_is_cmd (lcd_is_cmd),
      .lcd_req    (lcd_req),
      .lcd_ack    (lcd_ack)
   );

`ifdef LCD_CURSOR_EN
   localparam logic [7:0] EXP_DISP = 8'h0F;
`else
   localparam logic [7:0] EXP_DISP = 8'h0C;
`endif

   // controller model: ack 3 cycles after req, drops 1 cycle after req falls
   logic        force_ack = 1'b0;
   int unsigned acnt = 0;
   always @(posedge clk) begin
      if (force_ack) begin
         lcd_ack <= 1'b1;
      end else if (lcd_req) begin
         if (acnt >= 2) lcd_ack <= 1'b1;
         else acnt <= acnt + 1;
      end else begin
         acnt    <= 0;
         lcd_ack <= 1'b0;
      end
   end

   logic [8:0] log_q[$];
   logic       req_prev = 1'b0;
   logic       tracking = 1'b0;
   logic [8:0] held = '0;
   int         stable_err = 0;
   always @(negedge clk) begin
      if (!rst) begin
         req_prev = 1'b0;
         tracking = 1'b0;
      end else begin
         if (lcd_req && !req_prev) begin
            log_q.push_back({lcd_is_cmd, lcd_data});
            held     = {lcd_is_cmd, lcd_data};
            tracking = 1'b1;
         end else if (tracking && (lcd_req || lcd_ack)) begin
            if ({lcd_is_cmd, lcd_data} != held) stable_err++;
         end else begin
            tracking = 1'b0;
         end
         req_prev = lcd_req;
      end
   end

   int total = 0;
   int bad = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic wait_ready(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 400; i++) begin
         @(negedge clk);
         if (char_ready) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic wait_init(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 600; i++) begin
         @(negedge clk);
         if (init_done) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic check_init(input string pfx);
      logic [8:0] exp_init[4];
      exp_init[0] = 9'h138;
      exp_init[1] = {1'b1, EXP_DISP};
      exp_init[2] = 9'h106;
      exp_init[3] = 9'h101;
      check({pfx, "_count"}, log_q.size(), 4);
      for (int i = 0; i < 4; i++)
         if (i < log_q.size()) check($sformatf("%s_cmd%0d", pfx, i), log_q[i], exp_init[i]);
   endtask

   typedef struct {
      logic [7:0] ch;
      int         n;
      logic [8:0] e0;
      logic [8:0] e1;
   } vec_t;
   vec_t vecs[$];

   function automatic void add_vec(input logic [7:0] ch, input int n,
                                   input logic [8:0] e0, input logic [8:0] e1);
      vec_t v;
      v.ch = ch; v.n = n; v.e0 = e0; v.e1 = e1;
      vecs.push_back(v);
   endfunction

   initial begin
      bit ok;
      int cnt;
      logic [7:0] c;

      // cursor starts at row0 col1 after the hand-written 'A'
      for (int i = 0; i < 14; i++) begin
         c = 8'h42 + 8'(i);
         add_vec(c, 1, {1'b0, c}, '0);
      end
      add_vec(8'h50, 2, 9'h050, 9'h1C0);
      for (int i = 0; i < 16; i++) begin
         c = 8'h61 + 8'(i);
         if (i == 15) add_vec(c, 2, {1'b0, c}, 9'h180);
         else         add_vec(c, 1, {1'b0, c}, '0);
      end
      for (int i = 0; i < 5; i++) begin
         c = 8'h30 + 8'(i);
         add_vec(c, 1, {1'b0, c}, '0);
      end
      add_vec(8'h0A, 1, 9'h1C0, '0);
      add_vec(8'h0C, 1, 9'h101, '0);
      for (int i = 0; i < 16; i++) begin
         c = 8'h21 + 8'(i);
         if (i == 15) add_vec(c, 2, {1'b0, c}, 9'h1C0);
         else         add_vec(c, 1, {1'b0, c}, '0);
      end

      rst = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_char_ready", char_ready, 0);
      check("rst_init_done", init_done, 0);
      check("rst_lcd_req", lcd_req, 0);
      check("rst_lcd_data", lcd_data, 0);
      check("rst_lcd_is_cmd", lcd_is_cmd, 0);

      log_q.delete();
      rst = 1'b1;
      wait_init(ok);
      check("init_timeout", ok, 1);
      check_init("init");
      check("init_done_hi", init_done, 1);
      check("init_char_ready", char_ready, 1);

      // acceptance latency and single data transfer
      log_q.delete();
      char_in    = 8'h41;
      char_valid = 1'b1;
      @(posedge clk);
      #1;
      check("acc_req_next", lcd_req, 1);
      check("acc_ready_drop", char_ready, 0);
      @(negedge clk);
      char_valid = 1'b0;
      wait_ready(ok);
      check("a_timeout", ok, 1);
      check("a_count", log_q.size(), 1);
      if (log_q.size() > 0) check("a_byte", log_q[0], 9'h041);

      for (int i = 0; i < vecs.size(); i++) begin
         log_q.delete();
         wait_ready(ok);
         check($sformatf("v%0d_ready", i), ok, 1);
         char_in    = vecs[i].ch;
         char_valid = 1'b1;
         @(negedge clk);
         char_valid = 1'b0;
         wait_ready(ok);
         check($sformatf("v%0d_done", i), ok, 1);
         check($sformatf("v%0d_count", i), log_q.size(), vecs[i].n);
         if (log_q.size() > 0) check($sformatf("v%0d_x0", i), log_q[0], vecs[i].e0);
         if (vecs[i].n == 2 && log_q.size() > 1)
            check($sformatf("v%0d_x1", i), log_q[1], vecs[i].e1);
      end

      // stale ack while idle must not start or complete anything
      log_q.delete();
      force_ack = 1'b1;
      cnt = 0;
      repeat (5) begin
         @(negedge clk);
         if (lcd_req) cnt++;
      end
      check("stale_req", cnt, 0);
      force_ack = 1'b0;
      repeat (3) @(negedge clk);
      check("stale_count", log_q.size(), 0);
      check("stale_ready", char_ready, 1);

      // reset while a transfer is in flight, controller holding ack afterwards
      wait_ready(ok);
      char_in    = 8'h58;
      char_valid = 1'b1;
      @(negedge clk);
      char_valid = 1'b0;
      check("mid_req_hi", lcd_req, 1);
      force_ack = 1'b1;
      rst       = 1'b0;
      repeat (2) @(negedge clk);
      check("mid_rst_req", lcd_req, 0);
      check("mid_rst_init_done", init_done, 0);
      check("mid_rst_ready", char_ready, 0);
      log_q.delete();
      rst = 1'b1;
      cnt = 0;
      repeat (10) begin
         @(negedge clk);
         if (lcd_req) cnt++;
      end
      check("held_ack_req", cnt, 0);
      check("held_ack_count", log_q.size(), 0);
      force_ack = 1'b0;
      wait_init(ok);
      check("reinit_timeout", ok, 1);
      check_init("reinit");
      check("reinit_ready", char_ready, 1);

      check("data_stable", stable_err, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
